mem_access: RTL

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_pkg.sv | 15 +
 rtl/mem_access_timeout_ctr.sv | 40 ++++
 rtl/mem_access.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared processor constants for the load/store stage: FSM encoding,
// wait-counter width and the default memory timeout.
package mem_access_pkg;

  localparam int          DATA_W          = 16;
  localparam int          CTR_W           = 8;
  localparam int unsigned TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10
  } mem_state_e;

endpackage

// File: rtl/mem_access_timeout_ctr.sv
// Saturating wait-cycle counter; expired flags the last WAIT cycle allowed
// before the access is declared failed.
module mem_timeout_ctr
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // Count holds the number of completed WAIT cycles, so the TIMEOUT-th
  // WAIT cycle sees TIMEOUT-1.
  localparam logic [CTR_W-1:0] LIMIT = CTR_W'(TIMEOUT - 1);

  logic [CTR_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != '1)) begin
      count_d = count_q + CTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && (count_q >= LIMIT);

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues one data-memory request per load or
// store, stalls upstream until it completes, and registers the writeback result.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              mem_rd,
  input  logic              mem_wr,
  output logic              stall,
  output logic              out_valid,
  output logic [DATA_W-1:0] memOut,
  output logic              err,
  output logic              dmem_en,
  output logic              dmem_wr,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_done
);

  mem_state_e        state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] mem_out_q, mem_out_d;
  logic              wr_q, wr_d;
  logic              out_valid_q, out_valid_d;
  logic              err_q, err_d;
  logic              is_access, mem_op, misaligned;
  logic              ctr_clear, ctr_en, ctr_expired;

  assign is_access  = in_valid & (mem_rd | mem_wr);
  assign mem_op     = is_access & ~addr[0];
  assign misaligned = is_access &  addr[0];

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout_ctr (
    .clk     (clk),
    .rst     (rst),
    .clear   (ctr_clear),
    .enable  (ctr_en),
    .expired (ctr_expired)
  );

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wr_d        = wr_q;
    out_valid_d = 1'b0;
    err_d       = 1'b0;
    mem_out_d   = '0;
    stall       = 1'b0;
    dmem_en     = 1'b0;
    ctr_clear   = 1'b0;
    ctr_en      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (mem_op) begin
          stall     = 1'b1;
          addr_d    = addr;
          wdata_d   = wdata;
          wr_d      = mem_wr;
          ctr_clear = 1'b1;
          state_d   = ST_REQ;
        end else if (in_valid) begin
          out_valid_d = 1'b1;
          err_d       = misaligned;
        end
      end
      ST_REQ: begin
        dmem_en = 1'b1;
        if (dmem_done) begin
          out_valid_d = 1'b1;
          mem_out_d   = wr_q ? '0 : dmem_rdata;
          state_d     = ST_IDLE;
        end else begin
          stall   = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        ctr_en = 1'b1;
        // A done arriving on the final allowed cycle still wins over timeout.
        if (dmem_done) begin
          out_valid_d = 1'b1;
          mem_out_d   = wr_q ? '0 : dmem_rdata;
          state_d     = ST_IDLE;
        end else if (ctr_expired) begin
          out_valid_d = 1'b1;
          err_d       = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (rst) stall = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      mem_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      mem_out_q   <= mem_out_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign err        = err_q;
  assign memOut     = mem_out_q;
  assign dmem_wr    = wr_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

endmodule
